tick_gen: RTL and testbench

Parametrised, synthesizable successor to the free-running testbench clock source for the traffic controller. It takes the single system clock and produces NUM_CH independent divided timebases. Each channel has a one-cycle tick strobe and a 50% square wave, gated by the strt_clk run request. The ticks drive the phase timers (seconds tick) and the amber blink (square wave).

---
 rtl/tick_gen_pkg.sv | 25 ++
 rtl/tick_chan.sv | 70 +++++++
 rtl/tick_gen.sv | 60 ++++++
 tb/tb_tick_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared definitions for the tick_gen timebase block: FSM encoding,
// default geometry and the board-level divisor constants.
package tick_gen_pkg;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  localparam int CNT_W_DEF  = 16;
  localparam int NUM_CH_DEF = 2;

  // Board oscillator; chosen so the 1 Hz divisor still fits a 16-bit counter.
  localparam int unsigned BOARD_CLK_HZ = 32'd32768;

  function automatic int unsigned hz_to_div(input int unsigned clk_hz,
                                            input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  localparam int unsigned DIV_1HZ   = hz_to_div(BOARD_CLK_HZ, 32'd1);
  // Ticks at 2 Hz so the channel's square wave blinks at 1 Hz.
  localparam int unsigned DIV_BLINK = hz_to_div(BOARD_CLK_HZ, 32'd2);

endpackage

// File: rtl/tick_chan.sv
// One divider channel: counts div_q cycles per period, emits a one-cycle
// tick at each period boundary and toggles sq on every tick.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             start,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             sq
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    if (start) begin
      cnt_d = '0;
      div_d = div;
      sq_d  = 1'b0;
    end else if (run) begin
      if (div_q == '0) begin
        // Parked: keep sampling until a nonzero divisor arrives.
        cnt_d = '0;
        div_d = div;
      end else if (cnt_q == div_q - ONE) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
        div_d  = div;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      // Stopped or stopping: divisor is kept, everything else clears.
      cnt_d = '0;
      sq_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel timebase: a STOPPED/RUNNING FSM gated by strt_clk drives
// NUM_CH independent tick_chan dividers.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    strt_clk,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq,
  output logic                    running
);

  state_e state_q, state_d;
  logic   start_s;
  logic   run_s;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: begin
        if (strt_clk) state_d = ST_RUNNING;
        else          state_d = ST_STOPPED;
      end
      ST_RUNNING: begin
        if (strt_clk) state_d = ST_RUNNING;
        else          state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_STOPPED;
    else     state_q <= state_d;
  end

  assign start_s = (state_q == ST_STOPPED) && strt_clk;
  assign run_s   = (state_q == ST_RUNNING) && strt_clk;
  assign running = (state_q == ST_RUNNING);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
    tick_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .run  (run_s),
      .start(start_s),
      .div  (div_i[n*CNT_W +: CNT_W]),
      .tick (tick[n]),
      .sq   (sq[n])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios plus random traffic
// against a deadline-based reference model.
module tb_tick_gen;
  localparam int CNT_W  = 16;
  localparam int NUM_CH = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    strt_clk = 1'b0;
  logic [NUM_CH*CNT_W-1:0] div_i = '0;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       sq;
  logic                    running;

  tick_gen #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .strt_clk(strt_clk), .div_i(div_i),
    .tick(tick), .sq(sq), .running(running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: absolute edge index of the next tick per channel.
  int  t_edge = 0;
  bit  run_m  = 0;
  int  dq_m   [NUM_CH];
  int  dl_m   [NUM_CH];
  bit  tick_m [NUM_CH];
  bit  sq_m   [NUM_CH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, t_edge, obs, exp);
    end
  endtask

  function automatic int div_of(input int ch);
    return int'(div_i[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    run_m = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      dq_m[c] = 0; dl_m[c] = 0; tick_m[c] = 0; sq_m[c] = 0;
    end
  endtask

  task automatic model_edge();
    t_edge++;
    if (!run_m) begin
      if (strt_clk) begin
        run_m = 1;
        for (int c = 0; c < NUM_CH; c++) begin
          dq_m[c] = div_of(c); tick_m[c] = 0; sq_m[c] = 0;
          dl_m[c] = t_edge + dq_m[c];
        end
      end
    end else if (!strt_clk) begin
      run_m = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        tick_m[c] = 0; sq_m[c] = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        tick_m[c] = 0;
        if (dq_m[c] == 0) begin
          dq_m[c] = div_of(c);
          dl_m[c] = t_edge + dq_m[c];
        end else if (t_edge == dl_m[c]) begin
          tick_m[c] = 1;
          sq_m[c]   = ~sq_m[c];
          dq_m[c]   = div_of(c);
          dl_m[c]   = t_edge + dq_m[c];
        end
      end
    end
  endtask

  task automatic compare_all(input string phase);
    check_eq({phase, ":running"}, 32'(running), 32'(run_m));
    for (int c = 0; c < NUM_CH; c++) begin
      check_eq($sformatf("%s:tick%0d", phase, c), 32'(tick[c]), 32'(tick_m[c]));
      check_eq($sformatf("%s:sq%0d", phase, c), 32'(sq[c]), 32'(sq_m[c]));
    end
  endtask

  task automatic step(input string phase, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all(phase);
    end
  endtask

  task automatic set_div(input int ch, input int v);
    div_i[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  initial begin
    model_reset();
    // Reset and idle
    #12;
    check_eq("reset:tick", 32'(tick), 32'd0);
    check_eq("reset:sq", 32'(sq), 32'd0);
    check_eq("reset:running", 32'(running), 32'd0);
    rst = 1'b0;
    step("idle", 20);

    // Basic divide: ch0=5, ch1=3
    set_div(0, 5); set_div(1, 3);
    strt_clk = 1'b1;
    step("basic", 40);

    // Divisor change two cycles into a period of 4
    strt_clk = 1'b0; set_div(0, 4);
    step("stop1", 2);
    strt_clk = 1'b1;
    step("chg_start", 1);
    step("chg_pre", 2);
    set_div(0, 7);
    step("chg", 30);

    // Edge divisors: 1 and 0, then 0 -> 2
    strt_clk = 1'b0; set_div(0, 1); set_div(1, 0);
    step("stop2", 2);
    strt_clk = 1'b1;
    step("edge", 10);
    set_div(1, 2);
    step("unpark", 10);

    // Stop exactly on a terminal-count edge, then restart
    strt_clk = 1'b0; set_div(0, 5); set_div(1, 3);
    step("stop3", 2);
    strt_clk = 1'b1;
    step("pre_tc", 1);
    begin : find_tc
      int budget = 20;
      while (dl_m[0] != t_edge + 1 && budget > 0) begin
        step("pre_tc", 1);
        budget--;
      end
      check_eq("tc_budget", 32'(dl_m[0] == t_edge + 1), 32'd1);
    end
    strt_clk = 1'b0;
    step("stop_tc", 1);
    check_eq("stop_tc:tick0", 32'(tick[0]), 32'd0);
    check_eq("stop_tc:sq0", 32'(sq[0]), 32'd0);
    step("stop_tc", 2);
    strt_clk = 1'b1;
    step("restart", 15);

    // Async reset between edges
    #2 rst = 1'b1;
    #1;
    check_eq("arst:tick", 32'(tick), 32'd0);
    check_eq("arst:sq", 32'(sq), 32'd0);
    check_eq("arst:running", 32'(running), 32'd0);
    model_reset();
    strt_clk = 1'b0;
    #1 rst = 1'b0;
    step("post_rst", 5);
    strt_clk = 1'b1;
    step("post_rst_run", 20);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(7, 0) == 0) set_div(c, int'($urandom_range(12, 0)));
      if ($urandom_range(39, 0) == 0) strt_clk = ~strt_clk;
      step("rand", 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
